// File: rtl/i2c_master_multibyte.sv
// i2c_master_multibyte: I2C master, START + 7-bit address/RW + 0..MAX_BYTES
// data bytes with per-byte ACK and STOP. Open-drain SDA, push-pull SCL.
module i2c_master_multibyte #(
    parameter int         CLOCK_FREQ = 60000000,
    parameter int         I2C_RATE   = 30000,
    parameter int         MAX_BYTES  = 2,
    parameter logic [6:0] SLAVE_ADDR = 7'b1001001
) (
    input  logic                   clock,
    input  logic                   Reset,
    input  logic                   Go,
    input  logic                   ReadOrWrite,
    input  logic [3:0]             ByteCount,
    input  logic [8*MAX_BYTES-1:0] TxData,
    output logic [8*MAX_BYTES-1:0] RxData,
    output logic                   Busy,
    output logic                   Done,
    output logic                   AckError,
    inout  wire                    SDA,
    output logic                   SCL
);
    localparam int QUARTER = CLOCK_FREQ / (4 * I2C_RATE);
    localparam int QW = (QUARTER > 1) ? $clog2(QUARTER) : 1;
    localparam logic [QW-1:0] QLAST = QW'(QUARTER - 1);
    localparam logic [3:0] MAXB = 4'(MAX_BYTES);
    localparam int TW = 8 * MAX_BYTES;
    localparam int IW = $clog2(TW);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_WR,
        S_WR_ACK, S_RD, S_RD_ACK, S_STOP, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [QW-1:0]   qcnt_q, qcnt_d;
    logic [1:0]      ph_q, ph_d;
    logic [2:0]      bit_q, bit_d;
    logic [3:0]      idx_q, idx_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            rw_q, rw_d;
    logic [TW-1:0]   tx_q, tx_d;
    logic [7:0]      sh_q, sh_d;
    logic [7:0]      rsh_q, rsh_d;
    logic [TW-1:0]   rx_q, rx_d;
    logic            ack_q, ack_d;
    logic            ackerr_q, ackerr_d;
    logic            go_q;
    logic            scl_q, scl_d;
    logic            sdalow_q, sdalow_d;

    logic            busy;
    logic            tick;
    logic            sample;
    logic            end_bit;
    logic            go_edge;
    logic            sda_in;
    logic            hold;
    logic [3:0]      idx_nx;
    logic [IW-1:0]   off_cur;
    logic [IW-1:0]   off_nxt;

    assign busy    = (state_q != S_IDLE) && (state_q != S_DONE);
    assign tick    = busy && (qcnt_q == QLAST);
    assign sample  = tick && (ph_q == 2'd2);
    assign end_bit = tick && (ph_q == 2'd3);
    assign go_edge = Go && !go_q;
    assign sda_in  = SDA;
    assign idx_nx  = idx_q + 4'd1;
    assign off_cur = IW'({idx_q, 3'b000});
    assign off_nxt = IW'({idx_nx, 3'b000});
    assign hold    = (ph_q == 2'd0) && (qcnt_q == '0);

    // State register and all datapath registers
    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            state_q  <= S_IDLE;
            qcnt_q   <= '0;
            ph_q     <= '0;
            bit_q    <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            rw_q     <= 1'b0;
            tx_q     <= '0;
            sh_q     <= '0;
            rsh_q    <= '0;
            rx_q     <= '0;
            ack_q    <= 1'b0;
            ackerr_q <= 1'b0;
            go_q     <= 1'b0;
            scl_q    <= 1'b1;
            sdalow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            qcnt_q   <= qcnt_d;
            ph_q     <= ph_d;
            bit_q    <= bit_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            rw_q     <= rw_d;
            tx_q     <= tx_d;
            sh_q     <= sh_d;
            rsh_q    <= rsh_d;
            rx_q     <= rx_d;
            ack_q    <= ack_d;
            ackerr_q <= ackerr_d;
            go_q     <= Go;
            scl_q    <= scl_d;
            sdalow_q <= sdalow_d;
        end
    end

    // Next-state logic: quarter timing, bit/byte sequencing, ACK handling
    always_comb begin
        state_d  = state_q;
        qcnt_d   = '0;
        ph_d     = ph_q;
        bit_d    = bit_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        rw_d     = rw_q;
        tx_d     = tx_q;
        sh_d     = sh_q;
        rsh_d    = rsh_q;
        rx_d     = rx_q;
        ack_d    = ack_q;
        ackerr_d = ackerr_q;

        if (busy) qcnt_d = tick ? '0 : qcnt_q + 1'b1;
        if (tick) ph_d = ph_q + 2'd1;

        unique case (state_q)
            S_IDLE: begin
                ph_d = 2'd0;
                if (go_edge) begin
                    rw_d     = ReadOrWrite;
                    cnt_d    = (ByteCount > MAXB) ? MAXB : ByteCount;
                    tx_d     = TxData;
                    ackerr_d = 1'b0;
                    sh_d     = {SLAVE_ADDR, ReadOrWrite};
                    idx_d    = '0;
                    bit_d    = '0;
                    state_d  = S_START;
                end
            end
            S_START: begin
                if (tick && ph_q == 2'd2) begin
                    ph_d    = 2'd0;
                    state_d = S_ADDR;
                end
            end
            S_ADDR, S_WR: begin
                if (end_bit) begin
                    sh_d  = {sh_q[6:0], 1'b0};
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7)
                        state_d = (state_q == S_ADDR) ? S_ADDR_ACK : S_WR_ACK;
                end
            end
            S_ADDR_ACK: begin
                if (sample) ack_d = sda_in;
                if (end_bit) begin
                    if (ack_q) begin
                        ackerr_d = 1'b1;
                        state_d  = S_STOP;
                    end else if (cnt_q == 4'd0) begin
                        state_d = S_STOP;
                    end else if (rw_q) begin
                        state_d = S_RD;
                    end else begin
                        sh_d    = tx_q[off_cur +: 8];
                        state_d = S_WR;
                    end
                end
            end
            S_WR_ACK: begin
                if (sample) ack_d = sda_in;
                if (end_bit) begin
                    if (ack_q) begin
                        ackerr_d = 1'b1;
                        state_d  = S_STOP;
                    end else begin
                        idx_d = idx_nx;
                        if (idx_nx == cnt_q) begin
                            state_d = S_STOP;
                        end else begin
                            sh_d    = tx_q[off_nxt +: 8];
                            state_d = S_WR;
                        end
                    end
                end
            end
            S_RD: begin
                if (sample) begin
                    rsh_d = {rsh_q[6:0], sda_in};
                    if (bit_q == 3'd7)
                        rx_d[off_cur +: 8] = {rsh_q[6:0], sda_in};
                end
                if (end_bit) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = S_RD_ACK;
                end
            end
            S_RD_ACK: begin
                if (end_bit) begin
                    idx_d   = idx_nx;
                    state_d = (idx_nx == cnt_q) ? S_STOP : S_RD;
                end
            end
            S_STOP: begin
                if (end_bit) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Pad levels per state/quarter; SDA holds for the first clock of Q0
    // so it always changes after SCL has already fallen
    always_comb begin
        scl_d    = 1'b1;
        sdalow_d = 1'b0;
        unique case (state_q)
            S_START: begin
                scl_d    = (ph_q != 2'd2);
                sdalow_d = 1'b1;
            end
            S_ADDR, S_WR: begin
                scl_d    = ph_q[1];
                sdalow_d = ~sh_q[7];
            end
            S_ADDR_ACK, S_WR_ACK, S_RD: begin
                scl_d    = ph_q[1];
                sdalow_d = 1'b0;
            end
            S_RD_ACK: begin
                scl_d    = ph_q[1];
                sdalow_d = (idx_nx != cnt_q);
            end
            S_STOP: begin
                scl_d    = ph_q[1];
                sdalow_d = (ph_q != 2'd3);
            end
            default: begin
                scl_d    = 1'b1;
                sdalow_d = 1'b0;
            end
        endcase
        if (hold) sdalow_d = sdalow_q;
    end

    assign SCL      = scl_q;
    assign SDA      = sdalow_q ? 1'b0 : 1'bz;
    assign Busy     = busy;
    assign Done     = (state_q == S_DONE);
    assign AckError = ackerr_q;
    assign RxData   = rx_q;

endmodule

// File: tb/tb_i2c_master_multibyte.sv
// tb_i2c_master_multibyte: directed bench with a bus-level I2C slave model.
// QUARTER = 400/(4*10) = 10 clocks.
module tb_i2c_master_multibyte;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        go;
    logic        rw;
    logic [3:0]  bc;
    logic [15:0] tx;
    logic [15:0] rx;
    logic        busy;
    logic        done;
    logic        ackerr;
    logic        scl;
    wire         sda;

    logic        slv_low = 1'b0;
    logic        slv_ack_addr = 1'b1;
    logic        slv_ack_data = 1'b1;
    logic [7:0]  rd_data [0:1];

    assign sda = slv_low ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_master_multibyte #(
        .CLOCK_FREQ(400),
        .I2C_RATE  (10),
        .MAX_BYTES (2),
        .SLAVE_ADDR(7'b1001001)
    ) dut (
        .clock      (clk),
        .Reset      (rst_n),
        .Go         (go),
        .ReadOrWrite(rw),
        .ByteCount  (bc),
        .TxData     (tx),
        .RxData     (rx),
        .Busy       (busy),
        .Done       (done),
        .AckError   (ackerr),
        .SDA        (sda),
        .SCL        (scl)
    );

    int         checks = 0;
    int         failures = 0;

    int         pulses = 0;
    int         start_cnt = 0;
    int         stop_cnt = 0;
    int         done_cnt = 0;
    int         nbytes = 0;
    int         nack = 0;
    logic [7:0] seen [0:63];
    logic       ackbits [0:63];
    int         mon_bit = 8;
    int         mon_byte = -1;
    logic       mon_rw = 1'b0;
    logic       hi_flag = 1'b0;
    logic       pscl = 1'b1;
    logic       psda = 1'b1;
    logic [7:0] shr = 8'h00;

    // Bus monitor and slave: decodes START/STOP, bits, counts SCL pulses
    always @(negedge clk) begin
        logic s;
        logic d;
        s = scl;
        d = sda;
        if (!rst_n) slv_low = 1'b0;
        if (pscl && s && psda && !d) begin
            start_cnt++;
            mon_bit  = 8;
            mon_byte = -1;
            hi_flag  = 1'b0;
            slv_low  = 1'b0;
        end
        if (pscl && s && !psda && d) begin
            stop_cnt++;
            hi_flag = 1'b0;
        end
        if (!pscl && s) begin
            hi_flag = 1'b1;
            if (mon_bit == 8) begin
                if (nack < 64) ackbits[nack] = d;
                nack++;
            end else begin
                shr = {shr[6:0], d};
                if (mon_bit == 7) begin
                    if (nbytes < 64) seen[nbytes] = shr;
                    nbytes++;
                    if (mon_byte == 0) mon_rw = d;
                end
            end
        end
        if (pscl && !s) begin
            if (hi_flag) pulses++;
            hi_flag = 1'b0;
            if (mon_bit == 8) begin
                mon_bit = 0;
                mon_byte++;
            end else begin
                mon_bit++;
            end
            slv_low = 1'b0;
            if (rst_n) begin
                if (mon_bit == 8) begin
                    if (mon_byte == 0) slv_low = slv_ack_addr;
                    else if (!mon_rw) slv_low = slv_ack_data;
                end else if (mon_rw && mon_byte >= 1 && mon_byte <= 2) begin
                    slv_low = ~rd_data[mon_byte-1][7-mon_bit];
                end
            end
        end
        if (done) done_cnt++;
        pscl = s;
        psda = d;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_frame(input logic r, input logic [3:0] n,
                               input logic [15:0] d);
        @(posedge clk);
        #1;
        rw = r;
        bc = n;
        tx = d;
        go = 1'b1;
        @(posedge clk);
        #1;
        go = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (done !== 1'b1 && k < 4000) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_done_seen"}, 32'(k < 4000), 32'd1);
        repeat (20) @(negedge clk);
    endtask

    int p0, b0, a0, d0, s0, t0;

    task automatic snap();
        p0 = pulses;
        b0 = nbytes;
        a0 = nack;
        d0 = done_cnt;
        s0 = start_cnt;
        t0 = stop_cnt;
    endtask

    initial begin
        rd_data[0] = 8'h19;
        rd_data[1] = 8'h80;
        rst_n = 1'b0;
        go    = 1'b0;
        rw    = 1'b0;
        bc    = 4'd0;
        tx    = 16'h0000;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_scl", 32'(scl), 32'd1);
        chk("rst_sda", 32'(sda), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ackerr", 32'(ackerr), 32'd0);
        chk("rst_rx", 32'(rx), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);

        // write two bytes, slave ACKs
        snap();
        start_frame(1'b0, 4'd2, 16'hA501);
        chk("wr2_busy", 32'(busy), 32'd1);
        wait_done("wr2");
        chk("wr2_pulses", 32'(pulses - p0), 32'd27);
        chk("wr2_addr", 32'(seen[b0]), 32'h92);
        chk("wr2_b0", 32'(seen[b0+1]), 32'h01);
        chk("wr2_b1", 32'(seen[b0+2]), 32'hA5);
        chk("wr2_starts", 32'(start_cnt - s0), 32'd1);
        chk("wr2_stops", 32'(stop_cnt - t0), 32'd1);
        chk("wr2_dones", 32'(done_cnt - d0), 32'd1);
        chk("wr2_ackerr", 32'(ackerr), 32'd0);
        chk("wr2_idle", 32'(busy), 32'd0);

        // read two bytes: master ACKs first, NACKs last
        snap();
        start_frame(1'b1, 4'd2, 16'h0000);
        wait_done("rd2");
        chk("rd2_pulses", 32'(pulses - p0), 32'd27);
        chk("rd2_addr", 32'(seen[b0]), 32'h93);
        chk("rd2_mack1", 32'(ackbits[a0+1]), 32'd0);
        chk("rd2_mack2", 32'(ackbits[a0+2]), 32'd1);
        chk("rd2_rx", 32'(rx), 32'h8019);
        chk("rd2_dones", 32'(done_cnt - d0), 32'd1);
        chk("rd2_stops", 32'(stop_cnt - t0), 32'd1);

        // address NACK
        slv_ack_addr = 1'b0;
        snap();
        start_frame(1'b0, 4'd2, 16'h1234);
        wait_done("anack");
        chk("anack_ackerr", 32'(ackerr), 32'd1);
        chk("anack_pulses", 32'(pulses - p0), 32'd9);
        chk("anack_dones", 32'(done_cnt - d0), 32'd1);
        chk("anack_stops", 32'(stop_cnt - t0), 32'd1);
        chk("anack_rx_kept", 32'(rx), 32'h8019);

        // zero-byte probe, AckError cleared by the new start
        slv_ack_addr = 1'b1;
        snap();
        start_frame(1'b0, 4'd0, 16'h0000);
        chk("probe_ackclr", 32'(ackerr), 32'd0);
        wait_done("probe");
        chk("probe_pulses", 32'(pulses - p0), 32'd9);
        chk("probe_addr", 32'(seen[b0]), 32'h92);
        chk("probe_ackerr", 32'(ackerr), 32'd0);
        chk("probe_dones", 32'(done_cnt - d0), 32'd1);

        // ByteCount above MAX_BYTES saturates to two bytes
        snap();
        start_frame(1'b0, 4'd5, 16'h3CC3);
        wait_done("sat");
        chk("sat_pulses", 32'(pulses - p0), 32'd27);
        chk("sat_b0", 32'(seen[b0+1]), 32'hC3);
        chk("sat_b1", 32'(seen[b0+2]), 32'h3C);

        // reset during 4th bit of data byte 1
        start_frame(1'b0, 4'd2, 16'h7E81);
        begin
            int k = 0;
            while (!(mon_byte == 1 && mon_bit == 3) && k < 4000) begin
                @(negedge clk);
                k++;
            end
            chk("rst_mid_reach", 32'(k < 4000), 32'd1);
        end
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_scl", 32'(scl), 32'd1);
        chk("rst_mid_sda", 32'(sda), 32'd1);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_rx", 32'(rx), 32'd0);
        repeat (30) @(negedge clk);
        chk("rst_hold_scl", 32'(scl), 32'd1);
        chk("rst_hold_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        snap();
        start_frame(1'b0, 4'd1, 16'h005A);
        wait_done("post_rst");
        chk("post_rst_pulses", 32'(pulses - p0), 32'd18);
        chk("post_rst_addr", 32'(seen[b0]), 32'h92);
        chk("post_rst_b0", 32'(seen[b0+1]), 32'h5A);
        chk("post_rst_starts", 32'(start_cnt - s0), 32'd1);
        chk("post_rst_dones", 32'(done_cnt - d0), 32'd1);

        // Go toggled while busy; data NACK on first byte
        slv_ack_data = 1'b0;
        snap();
        start_frame(1'b0, 4'd2, 16'h0FF0);
        repeat (200) @(posedge clk);
        #1;
        rw = 1'b1;
        bc = 4'd0;
        go = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        go = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        go = 1'b1;
        @(posedge clk);
        #1;
        go = 1'b0;
        wait_done("gobusy");
        chk("gobusy_pulses", 32'(pulses - p0), 32'd18);
        chk("gobusy_b0", 32'(seen[b0+1]), 32'hF0);
        chk("gobusy_starts", 32'(start_cnt - s0), 32'd1);
        chk("gobusy_ackerr", 32'(ackerr), 32'd1);
        chk("gobusy_dones", 32'(done_cnt - d0), 32'd1);

        // second transaction clears AckError at its start
        slv_ack_data = 1'b1;
        snap();
        start_frame(1'b0, 4'd1, 16'h00C6);
        chk("second_ackclr", 32'(ackerr), 32'd0);
        wait_done("second");
        chk("second_pulses", 32'(pulses - p0), 32'd18);
        chk("second_b0", 32'(seen[b0+1]), 32'hC6);
        chk("second_ackerr", 32'(ackerr), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop if the directed sequence ever stalls
    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/i2c_master_multibyte.md
Name: i2c_master_multibyte

Overview:
- Parametrised I2C master for the TMP101 temperature-sensor path.
- Generates START, a 7-bit slave address plus R/W bit, then 0..MAX_BYTES data bytes (write or read), with per-byte ACK handling and STOP.
- Replaces the single-address-byte controller/data-unit pair.
- Sits between the top-level Go/reset controls and the SDA/SCL pads; read data is presented to display logic.

Parameters:
- CLOCK_FREQ, 60000000, system clock frequency in Hz.
- I2C_RATE, 30000, SCL frequency in Hz.
- MAX_BYTES, 2, maximum data bytes per transaction (1..8).
- SLAVE_ADDR, 7'b1001001, 7-bit slave address (TMP101).

Ports:
- clock  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Go  input  1  a rising edge starts a transaction.
- ReadOrWrite  input  1  1 = read, 0 = write; sampled at start.
- ByteCount  input  4  number of data bytes (0..MAX_BYTES); sampled at start.
- TxData  input  8*MAX_BYTES  write bytes; byte 0 is bits [7:0] and is sent first, MSB first.
- RxData  output  8*MAX_BYTES  read bytes; first received byte goes to [7:0].
- Busy  output  1  high from start until STOP completes.
- Done  output  1  one-clock pulse when STOP completes.
- AckError  output  1  set on any slave NACK; cleared at next start.
- SDA  inout  1  open drain: driven 0 or released (Z), never driven 1.
- SCL  output  1  driven; idles high.

Behaviour:
- Reset (asynchronous, Reset=0):
  - State IDLE.
  - SCL=1, SDA released.
  - Busy=0, Done=0, AckError=0, RxData=0.
  - Quarter counter=0.
  - Holds while Reset is low, including mid-transaction; no STOP is issued.
- Timing:
  - QUARTER = CLOCK_FREQ/(4*I2C_RATE) clocks (500 at defaults); integer division.
  - The quarter counter runs only while Busy is high.
  - Each bit has four quarters: Q0 SCL=0 and SDA updated; Q1 SCL=0; Q2 SCL=1; Q3 SCL=1.
  - SDA is sampled on the last clock of Q2.
- Go:
  - Edge-detected via a registered copy of Go.
  - A rising edge in IDLE latches ReadOrWrite, ByteCount (saturated to MAX_BYTES) and TxData, clears AckError, sets Busy on the next clock, and enters START.
  - Go edges while Busy are ignored.
- States:
  - IDLE -> START on a Go edge.
  - START: SDA pulled low while SCL=1 for 2 quarters, then SCL=0 for 1 quarter -> ADDR.
  - ADDR: 8 bits = {SLAVE_ADDR, ReadOrWrite}, MSB first -> ADDR_ACK.
  - ADDR_ACK: SDA released for 1 bit; sampled 1 sets AckError and goes -> STOP. Otherwise: ByteCount=0 -> STOP; read -> RD; write -> WR.
  - WR: 8 bits of the current byte -> WR_ACK.
  - WR_ACK: SDA released; NACK sets AckError -> STOP. Otherwise increment the byte index; if index = ByteCount -> STOP, else -> WR.
  - RD: SDA released; 8 bits shifted in MSB first and stored to the RxData slot when bit 8 is sampled -> RD_ACK.
  - RD_ACK: master drives ACK (0) if more bytes remain, NACK (released) on the last byte. Then -> RD or STOP.
  - STOP: Q0–Q1 SDA low, SCL low; Q2 SCL high; Q3 SDA released (rising while SCL high) -> DONE.
  - DONE: Busy=0, Done=1 for one clock -> IDLE.
- Frame length: SCL pulses = 9*(1+n), where n = bytes actually transferred.
- RxData slots not read in a transaction keep their previous values.
- Other outputs are unaffected by an abort, except AckError.

Test Plan:
- Sim config: CLOCK_FREQ=400, I2C_RATE=10, so QUARTER=10.
- Write 2 bytes: ReadOrWrite=0, ByteCount=2, TxData=16'hA5_01, slave ACKs all -> SDA shows 0x92, 0x01, 0xA5; 27 SCL pulses; Done pulses once; AckError=0; START/STOP edges occur while SCL=1.
- Read 2 bytes: ReadOrWrite=1, ByteCount=2, slave returns 0x19 then 0x80 -> address byte 0x93; master ACKs byte 1 and NACKs byte 2; RxData=16'h8019; 27 SCL pulses.
- Address NACK: slave leaves SDA high at ADDR_ACK -> AckError=1; STOP follows immediately after the 9th pulse; 9 SCL pulses total; Done pulses.
- ByteCount=0 write (probe) -> 9 SCL pulses, STOP, Done; AckError=0 with slave ACK.
- Reset=0 asserted during the 4th bit of byte 1 -> same clock: SCL=1, SDA=Z, Busy=0. After release a Go edge starts a clean new frame.
- Go toggled while Busy -> no effect; the frame completes unchanged. A later Go edge after Done starts a second transaction, and AckError is cleared at its start.
